posit_from_float_stream: RTL and testbench

POSIT_FROM_FLOAT_STREAM -- requirements
Module: posit_from_float_stream

---
 rtl/posit_from_float_stream.sv | 193 +++++++++++++++++++
 tb/tb_posit_from_float_stream.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_from_float_stream.sv
// Streaming multi-lane IEEE float -> posit converter: S1 unpacks and normalises each lane,
// S2 rounds (nearest, ties-to-even on the bit string) and packs. Saturating NaN/denormal statistics.
module posit_from_float_stream #(
    parameter int LANES       = 4,
    parameter int FLOAT_EXP   = 8,
    parameter int FLOAT_FRAC  = 23,
    parameter int POSIT_WIDTH = 16,
    parameter int POSIT_ES    = 1,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      inValid,
    output logic                                      inReady,
    input  logic [LANES*(1+FLOAT_EXP+FLOAT_FRAC)-1:0] inData,
    input  logic                                      inFtz,
    output logic                                      outValid,
    input  logic                                      outReady,
    output logic [LANES*POSIT_WIDTH-1:0]              outData,
    output logic [LANES-1:0]                          outNanMask,
    input  logic                                      statClear,
    output logic [STAT_WIDTH-1:0]                     statNanCount,
    output logic [STAT_WIDTH-1:0]                     statDenormCount
);
    localparam int F    = 1 + FLOAT_EXP + FLOAT_FRAC;
    localparam int BIAS = (2 ** (FLOAT_EXP - 1)) - 1;
    localparam int LZW  = $clog2(FLOAT_FRAC + 1);
    localparam int SCW  = FLOAT_EXP + LZW + 2;
    localparam int TW   = POSIT_ES + FLOAT_FRAC;
    localparam int VW   = 2 + TW + POSIT_WIDTH;
    localparam int CW   = $clog2(LANES + 1);
    localparam int SUMW = STAT_WIDTH + CW;
    localparam logic signed [SCW-1:0] kMax = SCW'(POSIT_WIDTH - 2);
    localparam logic signed [SCW-1:0] kMin = -kMax;

    typedef struct packed {
        logic             sgn;
        logic             zero;
        logic             nar;
        logic             nan;
        logic [SCW-1:0]   scale;
        logic [FLOAT_FRAC-1:0] mant;
    } laneT;

    function automatic logic [LZW-1:0] lzc(input logic [FLOAT_FRAC-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(FLOAT_FRAC);
        for (int i = 0; i < FLOAT_FRAC; i++) begin
            n = v[i] ? LZW'(FLOAT_FRAC - 1 - i) : n;
        end
        return n;
    endfunction

    function automatic laneT decodeLane(input logic [F-1:0] f, input logic ftz);
        laneT d;
        logic [FLOAT_EXP-1:0]  ex;
        logic [FLOAT_FRAC-1:0] frac;
        logic [LZW-1:0]        lz;
        ex   = f[FLOAT_FRAC +: FLOAT_EXP];
        frac = f[FLOAT_FRAC-1:0];
        lz   = lzc(frac);
        d     = '0;
        d.sgn = f[F-1];
        if (ex == {FLOAT_EXP{1'b1}}) begin
            d.nar = 1'b1;
            d.nan = |frac;
        end else if (ex == {FLOAT_EXP{1'b0}}) begin
            if ((frac == {FLOAT_FRAC{1'b0}}) || ftz) begin
                d.zero = 1'b1;
            end else begin
                // denormal: renormalise so the leading one becomes the hidden bit
                d.scale = SCW'(0) - SCW'(BIAS) - SCW'(lz);
                d.mant  = frac << (lz + LZW'(1));
            end
        end else begin
            d.scale = SCW'(ex) - SCW'(BIAS);
            d.mant  = frac;
        end
        return d;
    endfunction

    function automatic logic [POSIT_WIDTH-1:0] encodePosit(input laneT l);
        logic signed [SCW-1:0]  k;
        logic [SCW-1:0]         shamt;
        logic [TW-1:0]          tail;
        logic [VW-1:0]          sh;
        logic [POSIT_WIDTH-2:0] body;
        logic                   rnd;
        logic [POSIT_WIDTH-1:0] mag;
        k     = $signed(l.scale) >>> POSIT_ES;
        tail  = {l.scale[POSIT_ES-1:0], l.mant};
        shamt = k[SCW-1] ? ~k : k;
        // sign-extending shift emits the regime run ahead of its terminator bit
        sh    = $signed({(k[SCW-1] ? 2'b01 : 2'b10), tail, {POSIT_WIDTH{1'b0}}}) >>> shamt;
        body  = sh[VW-1 -: POSIT_WIDTH-1];
        rnd   = sh[VW-POSIT_WIDTH] & ((|sh[VW-POSIT_WIDTH-1:0]) | body[0]);
        if (k >= kMax) begin
            mag = {1'b0, {(POSIT_WIDTH-1){1'b1}}};
        end else if (k < kMin) begin
            mag = {{(POSIT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag = {1'b0, body + {{(POSIT_WIDTH-2){1'b0}}, rnd}};
        end
        if (l.nar) begin
            return {1'b1, {(POSIT_WIDTH-1){1'b0}}};
        end else if (l.zero) begin
            return {POSIT_WIDTH{1'b0}};
        end else begin
            return l.sgn ? ({POSIT_WIDTH{1'b0}} - mag) : mag;
        end
    endfunction

    function automatic logic [STAT_WIDTH-1:0] satAdd(input logic [STAT_WIDTH-1:0] c,
                                                     input logic [CW-1:0] inc);
        logic [SUMW-1:0] sum;
        sum = SUMW'(c) + SUMW'(inc);
        return (sum > SUMW'({STAT_WIDTH{1'b1}})) ? {STAT_WIDTH{1'b1}} : sum[STAT_WIDTH-1:0];
    endfunction

    logic                         s1Valid_r;
    laneT [LANES-1:0]             s1Lane_r;
    laneT [LANES-1:0]             dec_s;
    logic [CW-1:0]                nanInc_s;
    logic [CW-1:0]                denInc_s;
    logic [LANES*POSIT_WIDTH-1:0] encData_s;
    logic [LANES-1:0]             encMask_s;
    logic                         adv1_s;
    logic                         adv2_s;

    // handshake: a stage moves when its successor is empty or draining
    always_comb begin
        adv2_s  = !outValid || outReady;
        adv1_s  = !s1Valid_r || adv2_s;
        inReady = !reset && adv1_s;
    end

    // per-lane unpack of the incoming beat and its statistic increments
    always_comb begin
        nanInc_s = {CW{1'b0}};
        denInc_s = {CW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            dec_s[i] = decodeLane(inData[i*F +: F], inFtz);
            nanInc_s = nanInc_s + CW'(dec_s[i].nan);
            denInc_s = denInc_s + CW'(inFtz
                       && (inData[i*F+FLOAT_FRAC +: FLOAT_EXP] == {FLOAT_EXP{1'b0}})
                       && (inData[i*F +: FLOAT_FRAC] != {FLOAT_FRAC{1'b0}}));
        end
    end

    // round and pack every lane held in S1
    always_comb begin
        encData_s = {(LANES*POSIT_WIDTH){1'b0}};
        encMask_s = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            encData_s[i*POSIT_WIDTH +: POSIT_WIDTH] = encodePosit(s1Lane_r[i]);
            encMask_s[i] = s1Lane_r[i].nan;
        end
    end

    // pipeline registers and statistics counters
    always_ff @(posedge clock) begin
        if (reset) begin
            s1Valid_r       <= 1'b0;
            s1Lane_r        <= '0;
            outValid        <= 1'b0;
            outData         <= {(LANES*POSIT_WIDTH){1'b0}};
            outNanMask      <= {LANES{1'b0}};
            statNanCount    <= {STAT_WIDTH{1'b0}};
            statDenormCount <= {STAT_WIDTH{1'b0}};
        end else begin
            if (adv1_s) begin
                s1Valid_r <= inValid;
                if (inValid) begin
                    s1Lane_r <= dec_s;
                end
            end
            if (adv2_s) begin
                outValid <= s1Valid_r;
                if (s1Valid_r) begin
                    outData    <= encData_s;
                    outNanMask <= encMask_s;
                end
            end
            if (statClear) begin
                statNanCount    <= {STAT_WIDTH{1'b0}};
                statDenormCount <= {STAT_WIDTH{1'b0}};
            end else if (inValid && inReady) begin
                statNanCount    <= satAdd(statNanCount, nanInc_s);
                statDenormCount <= satAdd(statDenormCount, denInc_s);
            end
        end
    end
endmodule

// File: tb/tb_posit_from_float_stream.sv
// Bench for posit_from_float_stream: directed steps plus random beats, checked against a
// value-level posit model (nearest posit found by search, bit-string midpoints from n+1-bit posits).
module tb_posit_from_float_stream;
    localparam int LANES = 4;
    localparam int F     = 32;
    localparam int PW    = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                  reset, inValid, inFtz, outReady, statClear;
    logic [LANES*F-1:0]    inData;
    logic                  inReady, outValid, inReady4, outValid4;
    logic [LANES*PW-1:0]   outData, outData4;
    logic [LANES-1:0]      outNanMask, outNanMask4;
    logic [15:0]           statNanCount, statDenormCount;
    logic [3:0]            statNanCount4, statDenormCount4;

    posit_from_float_stream dut (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady), .inData(inData),
        .inFtz(inFtz), .outValid(outValid), .outReady(outReady), .outData(outData),
        .outNanMask(outNanMask), .statClear(statClear), .statNanCount(statNanCount),
        .statDenormCount(statDenormCount));

    posit_from_float_stream #(.STAT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady4), .inData(inData),
        .inFtz(inFtz), .outValid(outValid4), .outReady(outReady), .outData(outData4),
        .outNanMask(outNanMask4), .statClear(statClear), .statNanCount(statNanCount4),
        .statDenormCount(statDenormCount4));

    typedef struct {
        logic [63:0] data;
        logic [3:0]  mask;
        int          cyc;
        int          stalls;
    } beatT;

    beatT        q[$];
    int          checks = 0, failures = 0, cycNo = 0, stallCnt = 0;
    int          expNan = 0, expDen = 0, expNan4 = 0, expDen4 = 0;
    logic        prevRst = 1'b1, holdValid = 1'b0;
    logic [63:0] holdData;
    logic [3:0]  holdMask;
    logic        overrideOn = 1'b0;
    logic [15:0] overrideLane0;
    bit          acc;
    int          idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    // value of a positive posit pattern of width w, es = 1
    function automatic real pdec(input int pat, input int w);
        int i = w - 2, run = 0, k, e = 0, nf, fr;
        bit first = pat[i];
        while (i >= 0 && pat[i] == first) begin run++; i--; end
        i--;
        k = first ? run - 1 : -run;
        if (i >= 0) begin e = pat[i]; i--; end
        nf = (i >= 0) ? i + 1 : 0;
        fr = pat & ((1 << nf) - 1);
        return pow2(2 * k + e) * (1.0 + real'(fr) / pow2(nf));
    endfunction

    function automatic logic [15:0] nearest(input real x);
        int lo = 1, hi = 32767, mid;
        real m;
        if (x >= pdec(32767, PW)) return 16'h7FFF;
        if (x <= pdec(1, PW)) return 16'h0001;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (pdec(mid, PW) <= x) lo = mid; else hi = mid;
        end
        if (pdec(lo, PW) == x) return 16'(lo);
        m = pdec(2 * lo + 1, PW + 1);
        if (x > m) return 16'(lo + 1);
        if (x < m) return 16'(lo);
        return (lo % 2 == 1) ? 16'(lo + 1) : 16'(lo);
    endfunction

    function automatic logic [15:0] refPosit(input logic [31:0] f, input logic ftz);
        int ex = int'(f[30:23]);
        int fr = int'(f[22:0]);
        real x;
        logic [15:0] p;
        if (ex == 255) return 16'h8000;
        if (ex == 0 && (fr == 0 || ftz)) return 16'h0000;
        if (ex == 0) x = real'(fr) * pow2(-149);
        else x = (1.0 + real'(fr) * pow2(-23)) * pow2(ex - 127);
        p = nearest(x);
        return f[31] ? 16'h0000 - p : p;
    endfunction

    function automatic logic [31:0] rndFloat();
        int c = $urandom_range(0, 9);
        logic s = 1'($urandom);
        case (c)
            0: return {s, 31'h0};
            1: return {s, 8'hFF, 23'($urandom_range(1, 8388607))};
            2: return {s, 8'hFF, 23'h0};
            3: return {s, 8'h00, 23'($urandom_range(1, 8388607))};
            4: return $urandom;
            default: return {s, 8'($urandom_range(97, 157)), 23'($urandom)};
        endcase
    endfunction

    function automatic int satv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic cycle(output bit a);
        beatT e;
        int nInc = 0, dInc = 0;
        logic [31:0] f;
        @(negedge clock);
        cycNo++;
        a = inValid && inReady && !reset;
        check("inReady", 64'(inReady), 64'(!reset && !(q.size() >= 2 && !outReady)));
        if (reset) begin
            if (prevRst) begin
                check("rstOutValid", 64'(outValid), 64'd0);
                check("rstOutData", outData, 64'd0);
                check("rstMask", 64'(outNanMask), 64'd0);
                check("rstNanCnt", 64'(statNanCount), 64'd0);
                check("rstDenCnt4", 64'(statDenormCount4), 64'd0);
            end
        end else begin
            if (prevRst) check("outValidAfterRst", 64'(outValid), 64'd0);
            if (holdValid) begin
                check("holdValid", 64'(outValid), 64'd1);
                check("holdData", outData, holdData);
                check("holdMask", 64'(outNanMask), 64'(holdMask));
            end
            check("nanCnt", 64'(statNanCount), 64'(expNan));
            check("denCnt", 64'(statDenormCount), 64'(expDen));
            check("nanCnt4", 64'(statNanCount4), 64'(expNan4));
            check("denCnt4", 64'(statDenormCount4), 64'(expDen4));
            if (outValid && outReady) begin
                if (q.size() == 0) begin
                    check("spuriousBeat", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("outData", outData, e.data);
                    check("outNanMask", 64'(outNanMask), 64'(e.mask));
                    if (e.stalls == stallCnt) check("latency", 64'(cycNo - e.cyc), 64'd2);
                end
            end
            if (outValid && !outReady) stallCnt++;
            if (a) begin
                for (int l = 0; l < LANES; l++) begin
                    f = inData[l*F +: F];
                    e.data[l*PW +: PW] = refPosit(f, inFtz);
                    e.mask[l] = (f[30:23] == 8'hFF) && (f[22:0] != 23'h0);
                    nInc += int'(e.mask[l]);
                    dInc += int'(inFtz && f[30:23] == 8'h00 && f[22:0] != 23'h0);
                end
                if (overrideOn) e.data[15:0] = overrideLane0;
                e.cyc = cycNo;
                e.stalls = stallCnt;
                q.push_back(e);
            end
            if (statClear) begin
                expNan = 0; expDen = 0; expNan4 = 0; expDen4 = 0;
            end else begin
                expNan = satv(expNan + nInc, 65535);  expDen = satv(expDen + dInc, 65535);
                expNan4 = satv(expNan4 + nInc, 15);   expDen4 = satv(expDen4 + dInc, 15);
            end
            holdValid = outValid && !outReady;
            holdData = outData;
            holdMask = outNanMask;
        end
        if (reset) begin
            q.delete();
            expNan = 0; expDen = 0; expNan4 = 0; expDen4 = 0;
            holdValid = 1'b0;
        end
        prevRst = reset;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] lane0, input logic ftz, input logic [15:0] exp0);
        bit a = 1'b0;
        inData = {96'h0, lane0};
        inFtz = ftz;
        inValid = 1'b1;
        overrideOn = 1'b1;
        overrideLane0 = exp0;
        for (int t = 0; t < 20 && !a; t++) cycle(a);
        if (!a) check("sendTimeout", 64'd0, 64'd1);
        inValid = 1'b0;
        overrideOn = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        inValid = 1'b0;
        for (int t = 0; t < n; t++) cycle(a);
    endtask

    logic [31:0] stallIn [3];
    logic [15:0] stallExp [3];

    initial begin
        reset = 1'b1; inValid = 1'b0; inFtz = 1'b0; outReady = 1'b1; statClear = 1'b0;
        inData = '0;
        idle(3);
        reset = 1'b0;
        // basic values on consecutive cycles
        send(32'h3F800000, 1'b0, 16'h4000);
        send(32'h40800000, 1'b0, 16'h6000);
        send(32'hBF800000, 1'b0, 16'hC000);
        // NaN, inf, denormal, maxpos
        send(32'h7FC00000, 1'b0, 16'h8000);
        send(32'h7F800000, 1'b0, 16'h8000);
        send(32'h00000001, 1'b1, 16'h0000);
        send(32'h00000001, 1'b0, 16'h0001);
        send(32'h7F7FFFFF, 1'b0, 16'h7FFF);
        idle(4);
        check("nanAfterDirected", 64'(statNanCount), 64'd1);
        check("denAfterDirected", 64'(statDenormCount), 64'd1);

        // back-pressure: 5 stalled cycles then drain
        stallIn[0] = 32'h3F800000; stallExp[0] = 16'h4000;
        stallIn[1] = 32'h40000000; stallExp[1] = 16'h5000;
        stallIn[2] = 32'h40800000; stallExp[2] = 16'h6000;
        outReady = 1'b0; idx = 0; overrideOn = 1'b1; inFtz = 1'b0;
        for (int t = 0; t < 5; t++) begin
            inData = {96'h0, stallIn[idx]}; overrideLane0 = stallExp[idx]; inValid = 1'b1;
            cycle(acc);
            if (acc) idx++;
        end
        check("stallAccepted", 64'(idx), 64'd2);
        outReady = 1'b1;
        for (int t = 0; t < 10 && idx < 3; t++) begin
            inData = {96'h0, stallIn[idx]}; overrideLane0 = stallExp[idx]; inValid = 1'b1;
            cycle(acc);
            if (acc) idx++;
        end
        overrideOn = 1'b0;
        idle(5);
        check("stallDrained", 64'(q.size()), 64'd0);

        // counter saturation and clear priority
        statClear = 1'b1; idle(1); statClear = 1'b0;
        inData = {4{32'h7FC00000}};
        for (int t = 0; t < 20; t++) begin inValid = 1'b1; cycle(acc); end
        idle(3);
        check("nanSat4", 64'(statNanCount4), 64'd15);
        check("nan16", 64'(statNanCount), 64'd80);
        inValid = 1'b1; statClear = 1'b1; cycle(acc); statClear = 1'b0; inValid = 1'b0;
        check("clearPrio", 64'(statNanCount), 64'd0);
        check("clearPrio4", 64'(statNanCount4), 64'd0);
        idle(4);

        // reset one cycle after acceptance discards the beat
        send(32'h3F800000, 1'b0, 16'h4000);
        reset = 1'b1; idle(1); reset = 1'b0;
        idle(6);

        // random traffic
        for (int t = 0; t < 400; t++) begin
            for (int l = 0; l < LANES; l++) inData[l*F +: F] = rndFloat();
            inValid = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 3) != 0);
            inFtz = 1'($urandom);
            statClear = ($urandom_range(0, 49) == 0);
            cycle(acc);
        end
        statClear = 1'b0; outReady = 1'b1;
        idle(6);
        check("finalDrain", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
